// File: rtl/snoop_buf_sched.sv
// Ring of NUM_BUFS packet buffers shared between a snooper (filler) and a CPU (consumer).
// Optional drop statistics are built when SNOOP_DROP_COUNT_EN is defined.
module snoop_buf_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_BUFS   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] sn_wr_addr,
  input  logic [DATA_WIDTH-1:0] sn_wr_data,
  input  logic                  sn_wr_en,
  input  logic                  sn_done,
  input  logic                  sn_strobe,
  output logic                  sn_mem_ready,
  output logic [ADDR_WIDTH+1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en,
  output logic                  cpu_avail,
  output logic [1:0]            cpu_buf,
  input  logic                  cpu_acq,
  input  logic                  cpu_release,
  output logic [2:0]            occupancy
`ifdef SNOOP_DROP_COUNT_EN
  ,
  output logic [15:0]           drop_count,
  input  logic                  drop_clr
`endif
);

  typedef enum logic [1:0] {EMPTY, FILL, READY, PROC} bstate_t;

  bstate_t    st   [4];
  bstate_t    st_n [4];
  logic [1:0] wr_ptr, rd_ptr, wr_n, rd_n, wr_inc;
  logic       any_fill, fill_n, proc_n, avail_n;
  logic [2:0] occ_n;

  function automatic logic [1:0] inc(input logic [1:0] p);
    return (p == 2'(NUM_BUFS - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // The FILL buffer is always buffer[wr_ptr], so its index is the upper address.
  assign mem_wr_en   = sn_wr_en & sn_mem_ready;
  assign mem_wr_addr = {wr_ptr, sn_wr_addr};
  assign mem_wr_data = sn_wr_data;
  assign wr_inc      = inc(wr_ptr);

  always_comb begin
    any_fill = 1'b0;
    for (int i = 0; i < 4; i++) any_fill |= (st[i] == FILL);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) st_n[i] = st[i];
    wr_n = wr_ptr;
    rd_n = rd_ptr;
    // Closing a packet may open the next buffer at the same edge (no bubble).
    if (mem_wr_en && sn_done) begin
      st_n[wr_ptr] = READY;
      wr_n         = wr_inc;
      if (st[wr_inc] == EMPTY) st_n[wr_inc] = FILL;
    end else if (!any_fill && st[wr_ptr] == EMPTY) begin
      st_n[wr_ptr] = FILL;
    end
    // The held buffer is always buffer[rd_ptr]; release wins over acquire.
    if (st[rd_ptr] == PROC) begin
      if (cpu_release) begin
        st_n[rd_ptr] = EMPTY;
        rd_n         = inc(rd_ptr);
      end
    end else if (cpu_acq && cpu_avail) begin
      st_n[rd_ptr] = PROC;
    end
  end

  always_comb begin
    fill_n = 1'b0;
    proc_n = 1'b0;
    occ_n  = 3'd0;
    for (int i = 0; i < 4; i++) begin
      fill_n |= (st_n[i] == FILL);
      proc_n |= (st_n[i] == PROC);
      if (st_n[i] == READY || st_n[i] == PROC) occ_n = occ_n + 3'd1;
    end
    avail_n = (st_n[rd_n] == READY) && !proc_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) st[i] <= EMPTY;
      wr_ptr       <= 2'd0;
      rd_ptr       <= 2'd0;
      sn_mem_ready <= 1'b0;
      cpu_avail    <= 1'b0;
      cpu_buf      <= 2'd0;
      occupancy    <= 3'd0;
    end else begin
      for (int i = 0; i < 4; i++) st[i] <= st_n[i];
      wr_ptr       <= wr_n;
      rd_ptr       <= rd_n;
      sn_mem_ready <= fill_n;
      cpu_avail    <= avail_n;
      cpu_buf      <= rd_n;
      occupancy    <= occ_n;
    end
  end

`ifdef SNOOP_DROP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                               drop_count <= 16'd0;
    else if (drop_clr)                                        drop_count <= 16'd0;
    else if (sn_strobe && !sn_mem_ready && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`else
  logic strobe_unused;
  assign strobe_unused = sn_strobe;
`endif

endmodule

// File: tb/tb_snoop_buf_sched.sv
// Directed bench for snoop_buf_sched: a ring model built on packet counters is
// compared every cycle, plus literal checks at the key points of each scenario.
module tb_snoop_buf_sched;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] sn_wr_addr;
  logic [DW-1:0] sn_wr_data;
  logic          sn_wr_en, sn_done, sn_strobe;
  logic          sn_mem_ready;
  logic [AW+1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_en;
  logic          cpu_avail;
  logic [1:0]    cpu_buf;
  logic          cpu_acq, cpu_release;
  logic [2:0]    occupancy;
`ifdef SNOOP_DROP_COUNT_EN
  logic [15:0]   drop_count;
  logic          drop_clr;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  snoop_buf_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BUFS(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .sn_wr_addr(sn_wr_addr), .sn_wr_data(sn_wr_data), .sn_wr_en(sn_wr_en),
    .sn_done(sn_done), .sn_strobe(sn_strobe), .sn_mem_ready(sn_mem_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .cpu_avail(cpu_avail), .cpu_buf(cpu_buf), .cpu_acq(cpu_acq),
    .cpu_release(cpu_release), .occupancy(occupancy)
`ifdef SNOOP_DROP_COUNT_EN
    , .drop_count(drop_count), .drop_clr(drop_clr)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: packets committed/released counters, plus open-fill and held flags.
  int m_done, m_rel, m_drop;
  bit m_fill, m_held;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done <= 0; m_rel <= 0; m_drop <= 0; m_fill <= 0; m_held <= 0;
    end else begin
      if (sn_wr_en && m_fill && sn_done) begin
        m_done <= m_done + 1;
        m_fill <= (m_done - m_rel + 1) < NB;
      end else if (!m_fill && (m_done - m_rel) < NB) begin
        m_fill <= 1;
      end
      if (m_held) begin
        if (cpu_release) begin m_held <= 0; m_rel <= m_rel + 1; end
      end else if (cpu_acq && (m_done - m_rel) > 0) begin
        m_held <= 1;
      end
`ifdef SNOOP_DROP_COUNT_EN
      if (drop_clr) m_drop <= 0;
      else if (sn_strobe && !m_fill && m_drop < 16'hFFFF) m_drop <= m_drop + 1;
`endif
    end
  end

  always @(negedge clk) begin
    chk("ready", 32'(sn_mem_ready), 32'(m_fill));
    chk("avail", 32'(cpu_avail), 32'((m_done - m_rel) > 0 && !m_held));
    chk("cpu_buf", 32'(cpu_buf), 32'(m_rel % NB));
    chk("occ", 32'(occupancy), 32'(m_done - m_rel));
    chk("wr_en", 32'(mem_wr_en), 32'(sn_wr_en && m_fill));
    chk("wr_addr", 32'(mem_wr_addr), 32'({2'(m_done % NB), sn_wr_addr}));
    chk("wr_data", mem_wr_data, sn_wr_data);
`ifdef SNOOP_DROP_COUNT_EN
    chk("drop", 32'(drop_count), 32'(m_drop));
`endif
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Sends nfl flits of a 10-flit packet; flit 9 carries sn_done.
  task automatic send_pkt(input int p, input int nfl);
    for (int i = 0; i < nfl; i++) begin
      sn_wr_en = 1; sn_wr_addr = AW'(i); sn_wr_data = DW'(p * 100 + i); sn_done = (i == 9);
      #1;
      chk("no_bubble", 32'(mem_wr_en), 32'd1);
      chk("fill_idx", 32'(mem_wr_addr[AW+1:AW]), 32'(p % NB));
      @(posedge clk); #1;
    end
    sn_wr_en = 0; sn_done = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; sn_wr_addr = '0; sn_wr_data = '0; sn_wr_en = 0; sn_done = 0;
    sn_strobe = 0; cpu_acq = 0; cpu_release = 0;
`ifdef SNOOP_DROP_COUNT_EN
    drop_clr = 0;
`endif
    repeat (3) step();
    chk("rst_ready", 32'(sn_mem_ready), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_avail", 32'(cpu_avail), 32'd0);
    rst_n = 1;
    step();
    chk("rel_ready", 32'(sn_mem_ready), 32'd1);
    chk("rel_idx", 32'(mem_wr_addr[AW+1:AW]), 32'd0);

    // Fill the whole ring back to back with the CPU idle.
    for (int p = 0; p < 4; p++) begin
      send_pkt(p, 10);
      chk("occ_fill", 32'(occupancy), 32'(p + 1));
    end
    chk("full_ready", 32'(sn_mem_ready), 32'd0);
    chk("full_avail", 32'(cpu_avail), 32'd1);
    sn_wr_en = 1; #1;
    chk("full_drop_wr", 32'(mem_wr_en), 32'd0);
    step(); sn_wr_en = 0;

    // Release with nothing held is ignored.
    cpu_release = 1; step(); cpu_release = 0;
    chk("ign_rel_occ", 32'(occupancy), 32'd4);
    chk("ign_rel_buf", 32'(cpu_buf), 32'd0);

    for (int k = 0; k < 4; k++) begin
      cpu_acq = 1; step(); cpu_acq = 0;
      chk("acq_avail", 32'(cpu_avail), 32'd0);
      chk("acq_buf", 32'(cpu_buf), 32'(k));
      cpu_acq = 1; step(); cpu_acq = 0;
      chk("ign_acq_buf", 32'(cpu_buf), 32'(k));
      chk("ign_acq_occ", 32'(occupancy), 32'd4);
      cpu_release = 1; step(); cpu_release = 0;
      chk("rel_occ", 32'(occupancy), 32'd3);
      chk("rel_closed", 32'(sn_mem_ready), 32'd0);
      step();
      chk("reopen", 32'(sn_mem_ready), 32'd1);
      chk("reopen_idx", 32'(mem_wr_addr[AW+1:AW]), 32'(k));
      send_pkt(k + 4, 10);
      chk("refull", 32'(occupancy), 32'd4);
    end

`ifdef SNOOP_DROP_COUNT_EN
    sn_strobe = 1; repeat (5) step(); sn_strobe = 0;
    chk("drop5", 32'(drop_count), 32'd5);
    sn_strobe = 1; drop_clr = 1; step(); sn_strobe = 0; drop_clr = 0;
    chk("drop_clr", 32'(drop_count), 32'd0);
`endif

    // Reset in the middle of a packet.
    cpu_acq = 1; step(); cpu_acq = 0;
    chk("acq0_buf", 32'(cpu_buf), 32'd0);
    cpu_release = 1; step(); cpu_release = 0;
    step();
    send_pkt(8, 4);
    sn_wr_en = 1; sn_wr_addr = AW'(4); #1;
    rst_n = 0; #1;
    chk("mid_occ", 32'(occupancy), 32'd0);
    chk("mid_ready", 32'(sn_mem_ready), 32'd0);
    chk("mid_wr_en", 32'(mem_wr_en), 32'd0);
    sn_wr_en = 0; sn_wr_addr = '0;
    repeat (2) step();
    rst_n = 1;
    step();
    chk("post_ready", 32'(sn_mem_ready), 32'd1);
    chk("post_idx", 32'(mem_wr_addr[AW+1:AW]), 32'd0);
    chk("post_occ", 32'(occupancy), 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
